bg_scroll_renderer: RTL and testbench

// - Parametrised background renderer: maps screen pixel (DrawX, DrawY) to a palette-indexed image ROM

---
 rtl/bg_pkg.sv | 18 +
 rtl/bg_dda_axis.sv | 72 +++++++
 rtl/bg_scroll_renderer.sv | 197 +++++++++++++++++++
 tb/tb_bg_scroll_renderer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared definitions for the background scroll renderer.
//   coord_t        : 10-bit VGA pixel coordinate (DrawX / DrawY / scroll offsets)
//   VGA_SCR_W/H    : default visible resolution of the VGA controller
//   bits_for()     : minimum unsigned field width that can hold 'count' distinct values
package bg_pkg;

    typedef logic [9:0] coord_t;

    localparam int COORD_W   = 10;
    localparam int VGA_SCR_W = 640;
    localparam int VGA_SCR_H = 480;

    // Width needed to index 'count' entries (at least one bit).
    function automatic int bits_for(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/bg_dda_axis.sv
// One axis of the nearest-neighbour scaler: steps a source-image position by
// SRC/DST per destination pixel using an integer error accumulator.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load_i        : restart the axis at load_val_i with zero error
//   load_val_i    : start position (source units)
//   step_i        : advance by one destination pixel
//   pos_o         : position for the current cycle (already includes this cycle's load/step)
//   carry_o       : this cycle's step advanced by INT+1 instead of INT
// WRAP=1 wraps the position modulo SRC; WRAP=0 clamps it at SRC-1.
module bg_dda_axis #(
    parameter int SRC   = 712,
    parameter int DST   = 640,
    parameter int OUT_W = 10,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [OUT_W-1:0] load_val_i,
    input  logic             step_i,
    output logic [OUT_W-1:0] pos_o,
    output logic             carry_o
);

    localparam int INT   = SRC / DST;
    localparam int REM   = SRC % DST;
    localparam int ERR_W = $clog2(DST) + 1;
    localparam int PW    = OUT_W + 1;

    logic [OUT_W-1:0] pos_q, pos_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W-1:0] err_sum;
    logic [PW-1:0]    pos_sum;
    logic             carry;

    always_comb begin
        err_sum = err_q + ERR_W'(REM);
        carry   = (err_sum >= ERR_W'(DST));
        // One extra bit so the wrap/clamp compare sees the overflow.
        pos_sum = {1'b0, pos_q} + PW'(INT) + PW'(carry);

        pos_d   = pos_q;
        err_d   = err_q;
        carry_o = 1'b0;
        if (load_i) begin
            pos_d = load_val_i;
            err_d = '0;
        end else if (step_i) begin
            carry_o = carry;
            err_d   = carry ? (err_sum - ERR_W'(DST)) : err_sum;
            if (WRAP) begin
                // Position was < SRC and a step is at most SRC, so one subtract is enough.
                pos_d = (pos_sum >= PW'(SRC)) ? OUT_W'(pos_sum - PW'(SRC)) : pos_sum[OUT_W-1:0];
            end else begin
                pos_d = (pos_sum > PW'(SRC - 1)) ? OUT_W'(SRC - 1) : pos_sum[OUT_W-1:0];
            end
        end
        pos_o = pos_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= '0;
            err_q <= '0;
        end else begin
            pos_q <= pos_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/bg_scroll_renderer.sv
// Background renderer: maps screen pixel (DrawX, DrawY) to an image ROM address
// with nearest-neighbour scaling and horizontal wrap-around scrolling, then
// registers the palette colour.
// Ports:
//   vga_clk, reset              : pixel clock, asynchronous active-high reset
//   DrawX, DrawY, blank         : raster position and visible flag (1 = visible)
//   scroll_wr, scroll_val       : scroll request strobe and offset (image columns)
//   scroll_pend, scroll_err     : request waiting for frame boundary / rejected pulse
//   rom_addr, rom_q             : external ROM address (1 cycle after DrawX) and data
//   pal_index, pal_red/green/blue : combinational palette lookup
//   red, green, blue            : pixel colour, 2+ROM_LAT cycles after DrawX
// Scroll changes take effect only at the frame boundary (DrawY==SCR_H, DrawX==0)
// so a frame is always drawn with a single offset.
module bg_scroll_renderer
    import bg_pkg::*;
#(
    parameter int IMG_W   = 712,
    parameter int IMG_H   = 480,
    parameter int SCR_W   = VGA_SCR_W,
    parameter int SCR_H   = VGA_SCR_H,
    parameter int ADDR_W  = 19,
    parameter int IDX_W   = 4,
    parameter int COL_W   = 4,
    parameter int ROM_LAT = 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  coord_t            DrawX,
    input  coord_t            DrawY,
    input  logic              blank,
    input  logic              scroll_wr,
    input  coord_t            scroll_val,
    output logic              scroll_pend,
    output logic              scroll_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [COL_W-1:0]  pal_red,
    input  logic [COL_W-1:0]  pal_green,
    input  logic [COL_W-1:0]  pal_blue,
    output logic [COL_W-1:0]  red,
    output logic [COL_W-1:0]  green,
    output logic [COL_W-1:0]  blue
);

    localparam int LAT       = 2 + ROM_LAT;
    // The output register supplies the last cycle of blank delay.
    localparam int BLANK_DLY = LAT - 1;
    localparam int VINT      = IMG_H / SCR_H;

    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W * VINT);
    localparam logic [ADDR_W-1:0] ROW_STEP_C = ADDR_W'(IMG_W * (VINT + 1));
    localparam logic [ADDR_W-1:0] ROW_MAX    = ADDR_W'((IMG_H - 1) * IMG_W);
    localparam coord_t            ROW_LAST   = coord_t'(IMG_H - 1);

    if (bits_for(IMG_W * IMG_H) > ADDR_W) begin : g_bad_addr_w
        $error("ADDR_W too small for IMG_W*IMG_H");
    end
    if (ROM_LAT < 1) begin : g_bad_rom_lat
        $error("ROM_LAT must be at least 1");
    end
    if (IMG_W >= (1 << COORD_W) || IMG_H >= (1 << COORD_W)) begin : g_bad_img
        $error("image dimensions must fit a 10-bit coordinate");
    end

    logic line_start, col_step, row_step, commit, scroll_ok;

    always_comb begin
        line_start = (DrawX == '0);
        col_step   = (DrawX != '0) && (DrawX < coord_t'(SCR_W));
        row_step   = (DrawX == coord_t'(SCR_W)) && (DrawY < coord_t'(SCR_H - 1));
        commit     = (DrawY == coord_t'(SCR_H)) && (DrawX == '0);
        scroll_ok  = (scroll_val < coord_t'(IMG_W));
    end

    // Scroll request / frame-boundary commit
    coord_t active_q, active_d;
    coord_t pending_q, pending_d;
    logic   pend_q, pend_d;
    logic   err_q, err_d;

    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        if (commit && pend_q) begin
            active_d = pending_q;
            pend_d   = 1'b0;
        end
        // Evaluated after the commit so a write in the commit cycle queues behind it.
        if (scroll_wr && scroll_ok) begin
            pending_d = scroll_val;
            pend_d    = 1'b1;
        end
        err_d = scroll_wr && !scroll_ok;
    end

    // Column and row steppers
    coord_t col_pos, row_pos;
    logic   row_carry;
    logic   col_carry_unused;

    bg_dda_axis #(
        .SRC   (IMG_W),
        .DST   (SCR_W),
        .OUT_W (COORD_W),
        .WRAP  (1'b1)
    ) u_col (
        .clk        (vga_clk),
        .rst        (reset),
        .load_i     (line_start),
        .load_val_i (active_q),
        .step_i     (col_step),
        .pos_o      (col_pos),
        .carry_o    (col_carry_unused)
    );

    bg_dda_axis #(
        .SRC   (IMG_H),
        .DST   (SCR_H),
        .OUT_W (COORD_W),
        .WRAP  (1'b0)
    ) u_row (
        .clk        (vga_clk),
        .rst        (reset),
        .load_i     (commit),
        .load_val_i ('0),
        .step_i     (row_step),
        .pos_o      (row_pos),
        .carry_o    (row_carry)
    );

    // Row base tracks row_pos*IMG_W by adding one of two constant strides.
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    always_comb begin
        row_base_d = row_base_q;
        if (commit) begin
            row_base_d = '0;
        end else if (row_step) begin
            if (row_pos == ROW_LAST) begin
                row_base_d = ROW_MAX;
            end else begin
                row_base_d = row_base_q + (row_carry ? ROW_STEP_C : ROW_STEP);
            end
        end
        rom_addr_d = row_base_q + ADDR_W'(col_pos);
    end

    // Colour stage with delayed blank
    logic [BLANK_DLY-1:0] blank_q, blank_d;
    logic [COL_W-1:0]     red_q, green_q, blue_q;
    logic [COL_W-1:0]     red_d, green_d, blue_d;

    always_comb begin
        blank_d = {blank_q[BLANK_DLY-2:0], blank};
        red_d   = blank_q[BLANK_DLY-1] ? pal_red   : '0;
        green_d = blank_q[BLANK_DLY-1] ? pal_green : '0;
        blue_d  = blank_q[BLANK_DLY-1] ? pal_blue  : '0;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            active_q   <= '0;
            pending_q  <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            row_base_q <= '0;
            rom_addr_q <= '0;
            blank_q    <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
        end else begin
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            row_base_q <= row_base_d;
            rom_addr_q <= rom_addr_d;
            blank_q    <= blank_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign scroll_pend = pend_q;
    assign scroll_err  = err_q;
    assign rom_addr    = rom_addr_q;
    assign pal_index   = rom_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Self-checking bench for bg_scroll_renderer (ROM_LAT=2, default image geometry).
module tb_bg_scroll_renderer;

    localparam int IMG_W   = 712;
    localparam int IMG_H   = 480;
    localparam int SCR_W   = 640;
    localparam int SCR_H   = 480;
    localparam int ADDR_W  = 19;
    localparam int IDX_W   = 4;
    localparam int COL_W   = 4;
    localparam int ROM_LAT = 2;
    localparam int LAT     = 2 + ROM_LAT;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [9:0]        DrawX = '0;
    logic [9:0]        DrawY = '0;
    logic              blank = 1'b1;
    logic              scroll_wr = 1'b0;
    logic [9:0]        scroll_val = '0;
    logic              scroll_pend;
    logic              scroll_err;
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pal_index;
    logic [COL_W-1:0]  pal_red, pal_green, pal_blue;
    logic [COL_W-1:0]  red, green, blue;

    int total = 0;
    int bad   = 0;

    // Reference state: scroll offsets as the spec's request/commit rules define them.
    int m_active  = 0;
    int m_pending = 0;
    bit m_pend    = 1'b0;

    always #5 clk = ~clk;

    bg_scroll_renderer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .SCR_W(SCR_W), .SCR_H(SCR_H),
        .ADDR_W(ADDR_W), .IDX_W(IDX_W), .COL_W(COL_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .vga_clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .scroll_wr(scroll_wr), .scroll_val(scroll_val), .scroll_pend(scroll_pend),
        .scroll_err(scroll_err), .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue)
    );

    function automatic logic [3:0] rom_hash(input logic [ADDR_W-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]};
    endfunction

    // External ROM with two cycles of read latency, and a combinational palette.
    logic [IDX_W-1:0] rom_s1 = '0;
    logic [IDX_W-1:0] rom_s2 = '0;
    always @(posedge clk) begin
        rom_s1 <= rom_hash(rom_addr);
        rom_s2 <= rom_s1;
    end
    assign rom_q     = rom_s2;
    assign pal_red   = {1'b1, pal_index[2:0]};
    assign pal_green = ~pal_index;
    assign pal_blue  = pal_index ^ 4'h5;

    function automatic int exp_addr(input int x, input int y, input int act);
        int row;
        row = (y * IMG_H) / SCR_H;
        if (row > IMG_H - 1) row = IMG_H - 1;
        return row * IMG_W + (act + (x * IMG_W) / SCR_W) % IMG_W;
    endfunction

    function automatic logic [11:0] exp_colour(input int addr, input bit blk);
        logic [3:0] idx;
        idx = rom_hash(ADDR_W'(addr));
        return blk ? {1'b1, idx[2:0], ~idx, idx ^ 4'h5} : 12'h000;
    endfunction

    task automatic step(input int x, input int y, input bit wr, input int val, input bit blk);
        DrawX      = x[9:0];
        DrawY      = y[9:0];
        scroll_wr  = wr;
        scroll_val = val[9:0];
        blank      = blk;
        @(posedge clk);
        #1;
        scroll_wr = 1'b0;
    endtask

    task automatic drive_line(input int y, input int nx);
        for (int x = 0; x < nx; x++) begin
            step(x, y, 1'b0, 0, 1'b1);
            total++;
            if (rom_addr !== ADDR_W'(exp_addr(x, y, m_active))) begin
                bad++;
                $display("FAIL addr x=%0d y=%0d got=%0d want=%0d", x, y, rom_addr, exp_addr(x, y, m_active));
            end
        end
        step(SCR_W, y, 1'b0, 0, 1'b1);
    endtask

    task automatic scroll_write(input int y, input int val);
        bit exp_err;
        exp_err = (val >= IMG_W);
        step(SCR_W + 20, y, 1'b1, val, 1'b1);
        if (!exp_err) begin
            m_pending = val;
            m_pend    = 1'b1;
        end
        total++;
        if (scroll_err !== exp_err) begin
            bad++;
            $display("FAIL scroll_err val=%0d got=%0b want=%0b", val, scroll_err, exp_err);
        end
        total++;
        if (scroll_pend !== m_pend) begin
            bad++;
            $display("FAIL scroll_pend after write val=%0d got=%0b want=%0b", val, scroll_pend, m_pend);
        end
        step(SCR_W + 21, y, 1'b0, 0, 1'b1);
        total++;
        if (scroll_err !== 1'b0) begin
            bad++;
            $display("FAIL scroll_err pulse width got=%0b want=0", scroll_err);
        end
    endtask

    task automatic commit(input bit wr, input int val);
        bit exp_err;
        exp_err = wr && (val >= IMG_W);
        step(0, SCR_H, wr, val, 1'b1);
        if (m_pend) begin
            m_active = m_pending;
            m_pend   = 1'b0;
        end
        if (wr && !exp_err) begin
            m_pending = val;
            m_pend    = 1'b1;
        end
        total++;
        if (scroll_pend !== m_pend || scroll_err !== exp_err) begin
            bad++;
            $display("FAIL commit pend/err got=%0b/%0b want=%0b/%0b", scroll_pend, scroll_err, m_pend, exp_err);
        end
    endtask

    task automatic run_frame(input int wr_y, input int wr_val, input int full_y);
        for (int y = 0; y < SCR_H; y++) begin
            drive_line(y, (y == full_y) ? SCR_W : int'($urandom_range(1, 8)));
            if (y == wr_y) scroll_write(y, wr_val);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rom_addr !== '0 || {red, green, blue} !== 12'h000) begin
            bad++;
            $display("FAIL reset datapath addr=%0d rgb=%h want 0/000", rom_addr, {red, green, blue});
        end
        total++;
        if (scroll_pend !== 1'b0 || scroll_err !== 1'b0) begin
            bad++;
            $display("FAIL reset control pend=%0b err=%0b want 0/0", scroll_pend, scroll_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_line0();
        for (int x = 0; x < SCR_W; x++) begin
            step(x, 0, 1'b0, 0, 1'b1);
            total++;
            if (rom_addr !== ADDR_W'(exp_addr(x, 0, 0))) begin
                bad++;
                $display("FAIL line0 x=%0d got=%0d want=%0d", x, rom_addr, exp_addr(x, 0, 0));
            end
            if (x == SCR_W - 1) begin
                total++;
                if (rom_addr !== 19'd710) begin
                    bad++;
                    $display("FAIL line0 last got=%0d want=710", rom_addr);
                end
            end
        end
        step(SCR_W, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_rows();
        for (int y = 1; y < SCR_H; y++) begin
            if (y == 1 || y == SCR_H - 1) begin
                step(0, y, 1'b0, 0, 1'b1);
                total++;
                if (rom_addr !== ((y == 1) ? 19'd712 : 19'd341048)) begin
                    bad++;
                    $display("FAIL row start y=%0d got=%0d want=%0d", y, rom_addr, y * IMG_W);
                end
                for (int x = 1; x < 4; x++) begin
                    step(x, y, 1'b0, 0, 1'b1);
                    total++;
                    if (rom_addr !== ADDR_W'(exp_addr(x, y, 0))) begin
                        bad++;
                        $display("FAIL row y=%0d x=%0d got=%0d want=%0d", y, x, rom_addr, exp_addr(x, y, 0));
                    end
                end
                step(SCR_W, y, 1'b0, 0, 1'b1);
            end else begin
                drive_line(y, int'($urandom_range(1, 8)));
            end
        end
        commit(1'b0, 0);
    endtask

    task automatic test_scroll_wrap();
        run_frame(100, 700, 200);
        commit(1'b0, 0);
        for (int x = 0; x < SCR_W; x++) begin
            step(x, 0, 1'b0, 0, 1'b1);
            total++;
            if (rom_addr !== ADDR_W'(exp_addr(x, 0, m_active))) begin
                bad++;
                $display("FAIL wrap x=%0d got=%0d want=%0d", x, rom_addr, exp_addr(x, 0, m_active));
            end
            if (x == 0 || x == 11) begin
                total++;
                if (rom_addr !== ((x == 0) ? 19'd700 : 19'd0)) begin
                    bad++;
                    $display("FAIL wrap point x=%0d got=%0d want=%0d", x, rom_addr, (x == 0) ? 700 : 0);
                end
            end
        end
        step(SCR_W, 0, 1'b0, 0, 1'b1);
        for (int y = 1; y < SCR_H; y++) drive_line(y, int'($urandom_range(1, 8)));
        commit(1'b0, 0);
    endtask

    task automatic test_scroll_reject();
        run_frame(50, 712, -1);
        commit(1'b0, 0);
        run_frame(70, 1023, 3);
        commit(1'b0, 0);
    endtask

    task automatic test_commit_collision();
        run_frame(10, 5, -1);
        commit(1'b1, 9);
        total++;
        if (scroll_pend !== 1'b1) begin
            bad++;
            $display("FAIL collision pend got=%0b want=1", scroll_pend);
        end
        run_frame(-1, 0, 0);
        commit(1'b0, 0);
        run_frame(-1, 0, 479);
        commit(1'b0, 0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            run_frame(int'($urandom_range(0, SCR_H - 1)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, SCR_H - 1)));
            commit(bit'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
        end
    endtask

    task automatic test_blank_colour();
        logic [11:0] expq[$];
        logic [11:0] want;
        bit blk;
        for (int x = 0; x < 200; x++) begin
            blk = bit'($urandom_range(0, 2) != 0);
            step(x, 0, 1'b0, 0, blk);
            expq.push_back(exp_colour(exp_addr(x, 0, m_active), blk));
            if (expq.size() > LAT - 1) begin
                want = expq.pop_front();
                total++;
                if ({red, green, blue} !== want) begin
                    bad++;
                    $display("FAIL colour x=%0d got=%h want=%h", x - (LAT - 1), {red, green, blue}, want);
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        scroll_write(0, 123);
        for (int i = 0; i < LAT + 1; i++) step(SCR_W + 30, 0, 1'b0, 0, 1'b1);
        total++;
        if (red[3] !== 1'b1) begin
            bad++;
            $display("FAIL visible red msb before reset got=%0b want=1", red[3]);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({red, green, blue} !== 12'h000 || rom_addr !== '0) begin
            bad++;
            $display("FAIL async reset rgb=%h addr=%0d want 000/0", {red, green, blue}, rom_addr);
        end
        total++;
        if (scroll_pend !== 1'b0) begin
            bad++;
            $display("FAIL async reset pend got=%0b want=0", scroll_pend);
        end
        m_active = 0;
        m_pending = 0;
        m_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_line(0, 40);
        drive_line(1, 12);
        drive_line(2, 12);
    endtask

    initial begin
        test_reset();
        test_line0();
        test_rows();
        test_scroll_wrap();
        test_scroll_reject();
        test_commit_collision();
        test_random_frames();
        test_blank_colour();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
